// File: rtl/booth_mul_32_pkg.sv
// Shared ALU definitions for the sequential Booth multiplier.
package booth_mul_32_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier LSB and the bit shifted out last step.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        unique case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mul_32_cla.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained on group carries.
module cla_32_bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_carry_in,
    output logic [31:0] o_sum,
    output logic        o_carry_out
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;
    logic [7:0]  w_gg;
    logic [7:0]  w_gp;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Per-group lookahead: internal carries come straight from the group carry-in.
    always_comb begin
        w_c    = '0;
        w_gg   = '0;
        w_gp   = '0;
        w_c[0] = i_carry_in;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_gg[k]    = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k]    = w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k];
            w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
        end
    end

    assign o_sum       = w_p ^ w_c[31:0];
    assign o_carry_out = w_c[32];

endmodule

// File: rtl/booth_mul_32.sv
// Sequential signed 32x32 radix-2 Booth multiplier built around one cla_32_bit.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 32 Booth steps, then one writeback edge that latches hi/lo
// DONE  | one-cycle done pulse; start here begins the next product directly
module booth_mul_32
    import booth_mul_32_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_q_1;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_busy;
    logic             w_done;
    logic             w_load;
    logic             w_step;
    logic             w_wb;

    booth_op_t        w_op;
    logic [WIDTH:0]   w_mx;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH:0]   w_a_new;
    logic [WIDTH:0]   w_a_sel;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and datapath controls.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_wb   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                // Counter reaches WIDTH only after the last step; that edge is the writeback.
                if (r_count == LAST_CNT) begin
                    w_wb   = 1'b1;
                    w_next = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Booth recoding and adder operand select; subtraction is A + ~M + 1.
    always_comb begin
        w_op    = booth_decode(r_q[0], r_q_1);
        w_cin   = (w_op == BOOTH_SUB);
        w_mx    = w_cin ? ~{r_m[WIDTH-1], r_m} : {r_m[WIDTH-1], r_m};
        // Bit 32 is a one-bit full-add on top of the CLA so M = -2^31 cannot overflow A.
        w_a_new = {r_a[WIDTH] ^ w_mx[WIDTH] ^ w_cout, w_sum};
        w_a_sel = (w_op == BOOTH_NOP) ? r_a : w_a_new;
    end

    cla_32_bit u_cla (
        .i_a         (r_a[WIDTH-1:0]),
        .i_b         (w_mx[WIDTH-1:0]),
        .i_carry_in  (w_cin),
        .o_sum       (w_sum),
        .o_carry_out (w_cout)
    );

    // Operand load, Booth step with arithmetic right shift, and result writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_q_1   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_load) begin
            r_m     <= multiplicand;
            r_a     <= '0;
            r_q     <= multiplier;
            r_q_1   <= 1'b0;
            r_count <= '0;
        end else if (w_step) begin
            r_a     <= {w_a_sel[WIDTH], w_a_sel[WIDTH:1]};
            r_q     <= {w_a_sel[0], r_q[WIDTH-1:1]};
            r_q_1   <= r_q[0];
            r_count <= r_count + CNT_W'(1);
        end else if (w_wb) begin
            r_hi    <= r_a[WIDTH-1:0];
            r_lo    <= r_q;
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_booth_mul_32.sv
module tb_booth_mul_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_mul_32 dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed 64-bit multiplication.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    // Waits (bounded) for done; returns edges counted and whether hi/lo moved before done.
    task automatic wait_done(input string tag, input logic [63:0] prev,
                             output int edges, output bit moved);
        edges = 0;
        moved = 1'b0;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (done !== 1'b1 && {hi, lo} !== prev) moved = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int          e;
        bit          moved;
        logic [63:0] prev;
        logic [63:0] exp;
        exp = ref_mul(a, b);
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        prev   = {hi, lo};
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(tag, prev, e, moved);
        // done is first visible after the 33rd edge following the start edge.
        chk({tag, "_lat"}, 64'(e), 64'd33);
        chk({tag, "_hold"}, 64'(moved), 64'd0);
        chk({tag, "_prod"}, {hi, lo}, exp);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(done), 64'd0);
        chk({tag, "_keep"}, {hi, lo}, exp);
    endtask

    initial begin
        int          e;
        int          pulses;
        bit          moved;
        logic [63:0] got;
        logic [31:0] ra;
        logic [31:0] rb;

        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(32'd3, 32'd5, "m3x5");
        chk("m3x5_exact", {hi, lo}, 64'h00000000_0000000F);
        run_op(32'hFFFFFFF9, 32'd6, "m7x6");
        chk("m7x6_exact", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
        run_op(32'h80000000, 32'h80000000, "mminmin");
        chk("mminmin_exact", {hi, lo}, 64'h40000000_00000000);
        run_op(32'hFFFFFFFF, 32'h80000000, "m1min");
        chk("m1min_exact", {hi, lo}, 64'h00000000_80000000);
        run_op(32'h80000000, 32'h7FFFFFFF, "mminmax");
        run_op(32'd0, 32'h12345678, "mzero");

        // Random operands against the reference.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = 32'h80000000 | (ra & 32'hF);
            run_op(ra, rb, "rnd");
        end

        // start pulsed mid-RUN with new operands must be ignored.
        @(negedge clk);
        mcand  = 32'h7FFFFFFF;
        mplier = 32'h7FFFFFFF;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        mcand  = 32'd123;
        mplier = 32'd456;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        got    = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                got = {hi, lo};
            end
        end
        chk("ign_pulses", 64'(pulses), 64'd1);
        chk("ign_prod", got, 64'h3FFFFFFF_00000001);
        chk("ign_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        mcand  = 32'h00012345;
        mplier = 32'h00006789;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd2, 32'd2, "m2x2");
        chk("m2x2_lo", 64'(lo), 64'd4);

        // Back-to-back: start held through DONE, second operands 4 x -1.
        @(negedge clk);
        mcand  = 32'd5;
        mplier = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        mcand  = 32'd4;
        mplier = 32'hFFFFFFFF;
        wait_done("b2b1", {hi, lo}, e, moved);
        chk("b2b1_lat", 64'(e), 64'd33);
        chk("b2b1_prod", {hi, lo}, 64'd35);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_no_idle", 64'(busy), 64'd1);
        chk("b2b_pulse", 64'(done), 64'd0);
        wait_done("b2b2", {hi, lo}, e, moved);
        chk("b2b_gap", 64'(e + 1), 64'd34);
        chk("b2b2_hold", 64'(moved), 64'd0);
        chk("b2b2_prod", {hi, lo}, 64'hFFFFFFFF_FFFFFFFC);
        @(posedge clk);
        #1;
        chk("b2b2_pulse", 64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
